cp0_regfile: RTL

- System-coprocessor (CP0) register file and exception-state keeper for the MIPS pipeline.
- Receives the decoder's CP0 write requests (mtc0), read requests (mfc0), and the exception/eret events raised downstream (reserved instruction, syscall, break, overflow, address errors, interrupts).
- Holds Count, Compare, Status, Cause, EPC and BadVAddr.
- Generates the timer interrupt and supplies EPC for eret redirection; sits beside the MEM stage.

---
 rtl/cp0_regfile.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cp0_regfile.sv
// CP0 register file: Count/Compare/Status/Cause/EPC/BadVAddr plus exception and eret state updates.
// Define CP0_COUNT_TIMER_EN to build Count, Compare and the timer interrupt; otherwise they read as 0.
module cp0_regfile #(
    parameter logic [31:0] STATUS_RST = 32'h0040_0000,
    parameter logic [4:0]  RI_CODE    = 5'h0a
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);
    localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
    localparam logic [4:0]  ADDR_COUNT    = 5'd9;
    localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
    localparam logic [4:0]  ADDR_STATUS   = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
    localparam logic [4:0]  ADDR_EPC      = 5'd14;
    localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

    logic [31:0] status_reg, status_next;
    logic [31:0] cause_reg, cause_next;
    logic [31:0] epc_reg, epc_next;
    logic [31:0] badvaddr_reg, badvaddr_next;
    logic [31:0] count_val, compare_val;
    logic        timer_int;

    logic       exc_valid;
    logic       exc_addr_err;
    logic [4:0] exc_code;
    logic       eret;
    logic       wr_en;

    always_comb begin
        exc_valid    = 1'b1;
        exc_addr_err = 1'b0;
        exc_code     = 5'd0;
        case (excepttype_i)
            32'h0000_0001: exc_code = 5'd0;
            32'h0000_0004: begin exc_code = 5'd4; exc_addr_err = 1'b1; end
            32'h0000_0005: begin exc_code = 5'd5; exc_addr_err = 1'b1; end
            32'h0000_0008: exc_code = 5'd8;
            32'h0000_0009: exc_code = 5'd9;
            32'h0000_000a: exc_code = RI_CODE;
            32'h0000_000c: exc_code = 5'd12;
            default:       exc_valid = 1'b0;
        endcase
    end

    assign eret  = (excepttype_i == EXC_ERET);
    // Exceptions and eret take priority over a concurrent mtc0.
    assign wr_en = we_i & ~exc_valid & ~eret;

    always_comb begin
        status_next   = status_reg;
        cause_next    = cause_reg;
        epc_next      = epc_reg;
        badvaddr_next = badvaddr_reg;
        cause_next[15:10] = {int_i[5] | timer_int, int_i[4:0]};
        if (wr_en) begin
            case (waddr_i)
                ADDR_STATUS: status_next = data_i;
                ADDR_CAUSE: begin
                    cause_next[9:8]   = data_i[9:8];
                    cause_next[23:22] = data_i[23:22];
                end
                ADDR_EPC: epc_next = data_i;
                default: ;
            endcase
        end
        if (exc_valid) begin
            // Nested exceptions keep the original return address and BD.
            if (!status_reg[1]) begin
                epc_next      = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
                cause_next[31] = is_in_delayslot_i;
            end
            status_next[1]  = 1'b1;
            cause_next[6:2] = exc_code;
            if (exc_addr_err)
                badvaddr_next = bad_addr_i;
        end else if (eret) begin
            status_next[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            status_reg   <= STATUS_RST;
            cause_reg    <= '0;
            epc_reg      <= '0;
            badvaddr_reg <= '0;
        end else begin
            status_reg   <= status_next;
            cause_reg    <= cause_next;
            epc_reg      <= epc_next;
            badvaddr_reg <= badvaddr_next;
        end
    end

`ifdef CP0_COUNT_TIMER_EN
    logic [31:0] count_reg, count_next;
    logic [31:0] compare_reg, compare_next;
    logic        timer_int_reg, timer_int_next;
    logic        tick_reg;

    always_comb begin
        count_next     = tick_reg ? count_reg + 32'd1 : count_reg;
        compare_next   = compare_reg;
        timer_int_next = timer_int_reg;
        if (compare_reg != 32'd0 && count_reg == compare_reg)
            timer_int_next = 1'b1;
        if (wr_en && waddr_i == ADDR_COUNT)
            count_next = data_i;
        // Writing Compare is the only way to acknowledge the timer.
        if (wr_en && waddr_i == ADDR_COMPARE) begin
            compare_next   = data_i;
            timer_int_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_reg     <= '0;
            compare_reg   <= '0;
            timer_int_reg <= 1'b0;
            tick_reg      <= 1'b0;
        end else begin
            count_reg     <= count_next;
            compare_reg   <= compare_next;
            timer_int_reg <= timer_int_next;
            tick_reg      <= ~tick_reg;
        end
    end

    assign count_val   = count_reg;
    assign compare_val = compare_reg;
    assign timer_int   = timer_int_reg;
`else
    assign count_val   = '0;
    assign compare_val = '0;
    assign timer_int   = 1'b0;
`endif

    always_comb begin
        data_o = '0;
        case (raddr_i)
            ADDR_BADVADDR: data_o = badvaddr_reg;
            ADDR_COUNT:    data_o = count_val;
            ADDR_COMPARE:  data_o = compare_val;
            ADDR_STATUS:   data_o = status_reg;
            ADDR_CAUSE:    data_o = cause_reg;
            ADDR_EPC:      data_o = epc_reg;
            default:       data_o = '0;
        endcase
    end

    assign count_o     = count_val;
    assign compare_o   = compare_val;
    assign status_o    = status_reg;
    assign cause_o     = cause_reg;
    assign epc_o       = epc_reg;
    assign badvaddr_o  = badvaddr_reg;
    assign timer_int_o = timer_int;
endmodule
